// File: rtl/riscv_pkg.sv
// Constants and types shared between the fetch stage and the decode/control stage.
package riscv_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [OPCODE_W-1:0] {
        OPC_LW   = 7'b0000011,
        OPC_I    = 7'b0010011,
        OPC_SW   = 7'b0100011,
        OPC_R    = 7'b0110011,
        OPC_LUI  = 7'b0110111,
        OPC_BR   = 7'b1100011,
        OPC_JALR = 7'b1100111,
        OPC_JAL  = 7'b1101111
    } opcode_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO with flush; entry type is a parameter so the
// same block serves the in-flight tag queue and the instruction queue.
module fetch_fifo #(
    parameter type T = logic [31:0]
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       push_i,
    input  T           data_i,
    input  logic       pop_i,
    output logic [1:0] count_o,
    output T           head_o
);

    T           mem_q [2];
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    // A push into a full FIFO is accepted when the head pops in the same cycle.
    always_comb begin
        do_pop   = pop_i && (count_q != 2'd0);
        do_push  = push_i && ((count_q != 2'd2) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = !wr_ptr_q;
            if (do_pop)  rd_ptr_d = !rd_ptr_q;
            count_d = count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word requests, tags them with an epoch
// so stale responses after a redirect are dropped, and queues results for decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req_valid,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [XLEN-1:0]     imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    input  logic                stall,
    output logic                if_valid,
    output logic [XLEN-1:0]     if_pc,
    output logic [XLEN-1:0]     if_instr,
    output logic [OPCODE_W-1:0] if_opcode
);

    typedef struct packed {
        logic            epoch;
        logic [XLEN-1:0] pc;
    } tag_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            epoch_q, epoch_d;
    tag_t            tag_in, tag_head;
    entry_t          iq_in, iq_head;
    logic [1:0]      tag_count, iq_count;
    logic            req_fire, rsp_keep, iq_pop, head_valid;
    logic [2:0]      occ_eff;
    logic            redir_lo_unused;

    assign redir_lo_unused = ^redirect_pc[1:0];

    // occ_eff already credits this cycle's head pop so a full queue that is
    // draining can keep issuing back-to-back.
    always_comb begin
        head_valid     = reset && (iq_count != 2'd0);
        iq_pop         = head_valid && !stall && !redirect_valid;
        occ_eff        = 3'(iq_count) + 3'(tag_count) - 3'(iq_pop);
        imem_req_valid = reset && !redirect_valid && (occ_eff < 3'd2);
        imem_req_addr  = pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        tag_in         = '{epoch: epoch_q, pc: pc_q};
        rsp_keep       = imem_rsp_valid && (tag_count != 2'd0)
                         && (tag_head.epoch == epoch_q) && !redirect_valid;
        iq_in          = '{pc: tag_head.pc, instr: imem_rsp_data};

        pc_d    = pc_q;
        epoch_d = epoch_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
            epoch_d = !epoch_q;
        end else if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end

        if_valid  = head_valid;
        if_pc     = head_valid ? iq_head.pc : '0;
        if_instr  = head_valid ? iq_head.instr : XLEN'(NOP_INSTR);
        if_opcode = if_instr[OPCODE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
            epoch_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
        end
    end

    fetch_fifo #(.T(tag_t)) u_tag_q (
        .clk_i   (clk),
        .rst_ni  (reset),
        .flush_i (1'b0),
        .push_i  (req_fire),
        .data_i  (tag_in),
        .pop_i   (imem_rsp_valid),
        .count_o (tag_count),
        .head_o  (tag_head)
    );

    fetch_fifo #(.T(entry_t)) u_instr_q (
        .clk_i   (clk),
        .rst_ni  (reset),
        .flush_i (redirect_valid),
        .push_i  (rsp_keep),
        .data_i  (iq_in),
        .pop_i   (iq_pop),
        .count_o (iq_count),
        .head_o  (iq_head)
    );

    always_ff @(posedge clk) begin
        if (reset && imem_rsp_valid) begin
            assert (tag_count != 2'd0)
                else $error("fetch_unit: instruction response with no request in flight");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable memory model, a stream
// scoreboard of expected fetch PCs, and cycle-specific checks per scenario.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int lat   = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       mem_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] mon_pc;
    logic [31:0] mon_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        logic [6:0] op;
        case (a[4:2])
            3'd0:    op = 7'b0110011;
            3'd1:    op = 7'b0010011;
            3'd2:    op = 7'b0000011;
            3'd3:    op = 7'b0100011;
            3'd4:    op = 7'b1100011;
            3'd5:    op = 7'b0110111;
            3'd6:    op = 7'b1101111;
            default: op = 7'b1100111;
        endcase
        return {a[26:2], op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic restart_stream(input logic [31:0] start);
        exp_q.delete();
        for (int unsigned i = 0; i < 48; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Memory: accepts at the edge, answers in order after 'lat' cycles.
    always begin
        @(negedge clk);
        if (!reset) mem_q.delete();
        else if (imem_req_valid && imem_req_ready)
            mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
        @(posedge clk);
        #1;
        cyc++;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Scoreboard monitor: every instruction consumed by decode must be the next expected one.
    always @(negedge clk) begin
        if (reset && if_valid && !stall && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL stream_extra: got pc %h expected no instruction", if_pc);
            end else begin
                mon_pc    = exp_q.pop_front();
                mon_instr = instr_of(mon_pc);
                chk("stream_pc", if_pc, mon_pc);
                chk("stream_instr", if_instr, mon_instr);
                chk("stream_opcode", 32'(if_opcode), {25'd0, mon_instr[6:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "tb_fetch_unit watchdog");
    end

    initial begin
        bit found;
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        stall          = 1'b0;
        restart_stream(RESET_PC);

        tick(); tick(); smp();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, NOP);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_opcode", 32'(if_opcode), 32'h13);

        tick(); reset = 1'b1; smp();
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, RESET_PC);
        tick(); smp();
        chk("latency_c2_valid", 32'(if_valid), 32'd0);
        for (int unsigned k = 0; k < 3; k++) begin
            tick(); smp();
            chk("seq_valid", 32'(if_valid), 32'd1);
            chk("seq_pc", if_pc, RESET_PC + 32'(4 * k));
        end

        for (int unsigned k = 0; k < 5; k++) begin
            tick(); stall = 1'b1; smp();
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_pc_frozen", if_pc, RESET_PC + 32'd12);
            chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        end
        for (int unsigned k = 0; k < 3; k++) begin
            tick(); stall = 1'b0; smp();
            chk("unstall_valid", 32'(if_valid), 32'd1);
            chk("unstall_pc", if_pc, RESET_PC + 32'(12 + 4 * k));
        end

        found = 1'b0;
        for (int unsigned k = 0; k < 30; k++) begin
            tick(); lat = 3; smp();
            if (!imem_req_valid && !if_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("inflight2_reached", 32'(found), 32'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        lat            = 1;
        restart_stream(32'h0000_0100);
        smp();
        chk("redir_no_req", 32'(imem_req_valid), 32'd0);
        tick(); redirect_valid = 1'b0; redirect_pc = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 20; k++) begin
            smp();
            if (imem_req_valid) begin
                chk("redir_first_addr", imem_req_addr, 32'h0000_0100);
                found = 1'b1;
                break;
            end
            chk("redir_if_flushed", 32'(if_valid), 32'd0);
            tick();
        end
        chk("redir_req_seen", 32'(found), 32'd1);
        found = 1'b0;
        for (int unsigned k = 0; k < 20; k++) begin
            tick(); smp();
            if (if_valid) begin
                chk("redir_first_pc", if_pc, 32'h0000_0100);
                found = 1'b1;
                break;
            end
        end
        chk("redir_valid_seen", 32'(found), 32'd1);
        repeat (6) begin tick(); smp(); end

        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        restart_stream(32'h0000_0200);
        smp();
        chk("rr_rsp_present", 32'(imem_rsp_valid), 32'd1);
        chk("rr_head_present", 32'(if_valid), 32'd1);
        chk("rr_no_req", 32'(imem_req_valid), 32'd0);
        tick(); redirect_valid = 1'b0; smp();
        chk("rr_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rr_req_addr", imem_req_addr, 32'h0000_0200);
        chk("rr_flush1", 32'(if_valid), 32'd0);
        tick(); smp();
        chk("rr_flush2", 32'(if_valid), 32'd0);
        chk("rr_req_addr2", imem_req_addr, 32'h0000_0204);
        tick(); smp();
        chk("rr_first_valid", 32'(if_valid), 32'd1);
        chk("rr_first_pc", if_pc, 32'h0000_0200);

        for (int unsigned k = 0; k < 3; k++) begin
            tick(); imem_req_ready = 1'b0; smp();
            chk("nordy_valid", 32'(imem_req_valid), 32'd1);
            chk("nordy_addr_held", imem_req_addr, 32'h0000_020C);
        end
        tick(); imem_req_ready = 1'b1; smp();
        chk("rdy_addr", imem_req_addr, 32'h0000_020C);
        tick(); smp();
        chk("rdy_addr_next", imem_req_addr, 32'h0000_0210);
        tick(); smp();

        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        restart_stream(32'hFFFF_FFFC);
        smp();
        chk("wrap_redir_no_req", 32'(imem_req_valid), 32'd0);
        tick(); redirect_valid = 1'b0; redirect_pc = '0; smp();
        chk("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        tick(); smp();
        chk("wrap_addr_zero", imem_req_addr, 32'h0000_0000);
        tick(); smp();
        chk("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
        tick(); smp();
        chk("wrap_pc_zero", if_pc, 32'h0000_0000);

        for (int unsigned k = 0; k < 4; k++) begin
            tick(); stall = 1'b1; smp();
        end
        chk("full_if_valid", 32'(if_valid), 32'd1);
        chk("full_no_req", 32'(imem_req_valid), 32'd0);
        tick(); reset = 1'b0; stall = 1'b0; restart_stream(RESET_PC); smp();
        chk("rst_cycle_no_req", 32'(imem_req_valid), 32'd0);
        tick(); reset = 1'b1; smp();
        chk("rstfull_if_valid", 32'(if_valid), 32'd0);
        chk("rstfull_if_instr", if_instr, NOP);
        chk("rstfull_if_pc", if_pc, 32'd0);
        chk("rstfull_opcode", 32'(if_opcode), 32'h13);
        chk("rstfull_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rstfull_req_addr", imem_req_addr, RESET_PC);
        tick(); smp();
        tick(); smp();
        chk("restart_valid", 32'(if_valid), 32'd1);
        chk("restart_pc", if_pc, RESET_PC);
        repeat (4) begin tick(); smp(); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
